// File: rtl/l2_mem_responder_if.sv
// l2_mem_responder_if: I-port and D-port request/response bundle between the L2 and memory.
// Latency: none, plain wires.
// Backpressure: requests are level-held by the L2 until the matching one-cycle ready pulse.
interface l2_mem_responder_if #(
  parameter int DW = 128
);
  logic          Imem_read;
  logic          Imem_write;
  logic [27:0]   Imem_addr;
  logic [DW-1:0] Imem_wdata;
  logic          Imem_ready;
  logic [DW-1:0] Imem_rdata;

  logic          Dmem_read;
  logic          Dmem_write;
  logic [27:0]   Dmem_addr;
  logic [DW-1:0] Dmem_wdata;
  logic          Dmem_ready;
  logic [DW-1:0] Dmem_rdata;

  logic          proto_err;
  logic          init_busy;

  // Memory side
  modport slave (
    input  Imem_read, Imem_write, Imem_addr, Imem_wdata,
    input  Dmem_read, Dmem_write, Dmem_addr, Dmem_wdata,
    output Imem_ready, Imem_rdata, Dmem_ready, Dmem_rdata,
    output proto_err, init_busy
  );

  // L2 side
  modport master (
    output Imem_read, Imem_write, Imem_addr, Imem_wdata,
    output Dmem_read, Dmem_write, Dmem_addr, Dmem_wdata,
    input  Imem_ready, Imem_rdata, Dmem_ready, Dmem_rdata,
    input  proto_err, init_busy
  );
endinterface

// File: rtl/l2_mem_responder.sv
// l2_mem_responder: shared 2**AW x DW block store serving the L2 I-port and D-port, round-robin.
// Latency: ready pulses LATENCY cycles after grant; a single access is in flight at a time.
// Backpressure: a waiting port keeps its request high and is granted once the store is idle.
// Optional MEMRSP_ZERO_INIT_EN: zero the store after reset release, blocking grants meanwhile.
module l2_mem_responder #(
  parameter int LATENCY = 8,
  parameter int AW      = 10,
  parameter int DW      = 128
) (
  input logic               clk,
  input logic               proc_reset,
  l2_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  localparam int   CW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic P_I = 1'b0;
  localparam logic P_D = 1'b1;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_port;
  logic          r_last_grant;
  logic          r_op_wr;
  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_wdata;
  logic          r_i_ready;
  logic          r_d_ready;
  logic [DW-1:0] r_i_rdata;
  logic [DW-1:0] r_d_rdata;
  logic          r_proto_err;
  logic [DW-1:0] r_store [2**AW];

  logic          w_i_req;
  logic          w_d_req;
  logic          w_pick_d;
  logic          w_new_wr;
  logic [AW-1:0] w_new_idx;
  logic [DW-1:0] w_new_wdata;
  logic          w_init_run;
  logic [AW-1:0] w_init_idx;
  logic          w_grant;
  logic          w_commit;
  logic          w_c_port;
  logic          w_c_wr;
  logic [AW-1:0] w_c_idx;
  logic [DW-1:0] w_c_wdata;
  logic          w_both_err;
  logic          w_drop_err;
  logic          w_unused;

  assign w_i_req = bus.Imem_read | bus.Imem_write;
  assign w_d_req = bus.Dmem_read | bus.Dmem_write;

  // D wins only if I is silent or I was the last one served.
  assign w_pick_d    = w_d_req & (~w_i_req | (r_last_grant == P_I));
  // read and write together on a port is handled as a write
  assign w_new_wr    = w_pick_d ? bus.Dmem_write : bus.Imem_write;
  assign w_new_idx   = w_pick_d ? bus.Dmem_addr[AW-1:0] : bus.Imem_addr[AW-1:0];
  assign w_new_wdata = w_pick_d ? bus.Dmem_wdata : bus.Imem_wdata;

  assign w_grant = (r_state == S_IDLE) & (w_i_req | w_d_req) & ~w_init_run;

  // Commit happens on the edge that enters RESP; with LATENCY==1 that is the grant edge itself.
  assign w_commit  = ~proc_reset &
                     (((r_state == S_BUSY) && (r_cnt == CW'(1))) || ((LATENCY == 1) && w_grant));
  assign w_c_port  = (r_state == S_IDLE) ? w_pick_d    : r_port;
  assign w_c_wr    = (r_state == S_IDLE) ? w_new_wr    : r_op_wr;
  assign w_c_idx   = (r_state == S_IDLE) ? w_new_idx   : r_idx;
  assign w_c_wdata = (r_state == S_IDLE) ? w_new_wdata : r_wdata;

  assign w_both_err = (bus.Imem_read & bus.Imem_write) | (bus.Dmem_read & bus.Dmem_write);
  // granted port let go of its request while the access is still in flight
  assign w_drop_err = (r_state == S_BUSY) & ~((r_port == P_D) ? w_d_req : w_i_req);

  // address bits above the block index alias by design
  assign w_unused = &{1'b0, bus.Imem_addr[27:AW], bus.Dmem_addr[27:AW]};

`ifdef MEMRSP_ZERO_INIT_EN
  logic          r_init_run;
  logic [AW-1:0] r_init_idx;

  // Walk every block index once after reset release; restarts whenever reset is reasserted.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_init_run <= 1'b1;
      r_init_idx <= '0;
    end else if (r_init_run) begin
      r_init_idx <= r_init_idx + AW'(1);
      if (&r_init_idx) r_init_run <= 1'b0;
    end
  end

  assign w_init_run    = r_init_run;
  assign w_init_idx    = r_init_idx;
  assign bus.init_busy = r_init_run & ~proc_reset;
`else
  assign w_init_run    = 1'b0;
  assign w_init_idx    = '0;
  assign bus.init_busy = 1'b0;
`endif

  // Arbitration, latency count, response pulse, read data capture and sticky protocol flag.
  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_port       <= P_I;
      r_last_grant <= P_D;
      r_op_wr      <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_i_ready    <= 1'b0;
      r_d_ready    <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      if (w_both_err || w_drop_err) r_proto_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_port       <= w_pick_d;
            r_last_grant <= w_pick_d;
            r_op_wr      <= w_new_wr;
            r_idx        <= w_new_idx;
            r_wdata      <= w_new_wdata;
            r_cnt        <= CW'(LATENCY - 1);
            r_state      <= (LATENCY > 1) ? S_BUSY : S_RESP;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_commit) begin
        if (w_c_port == P_D) r_d_ready <= 1'b1;
        else                 r_i_ready <= 1'b1;
        if (!w_c_wr) begin
          if (w_c_port == P_D) r_d_rdata <= r_store[w_c_idx];
          else                 r_i_rdata <= r_store[w_c_idx];
        end
      end
    end
  end

  // Block store: zero walk has priority, otherwise the committing write lands here.
  always_ff @(posedge clk) begin
    if (w_init_run)              r_store[w_init_idx] <= '0;
    else if (w_commit && w_c_wr) r_store[w_c_idx]    <= w_c_wdata;
  end

  assign bus.Imem_ready = r_i_ready;
  assign bus.Dmem_ready = r_d_ready;
  assign bus.Imem_rdata = r_i_rdata;
  assign bus.Dmem_rdata = r_d_rdata;
  assign bus.proto_err  = r_proto_err;

endmodule
